// File: rtl/rip_trap_csr_pkg.sv
// Shared definitions for the RIP machine-mode CSR file: CSR addresses,
// trap causes, CSR op / trap FSM enums and the CSR read-modify-write helper.
// Carries the rip_config additions consumed by rip_trap_csr.
package rip_trap_csr_pkg;

    localparam logic [11:0] CSR_MTVEC  = 12'h305;
    localparam logic [11:0] CSR_MEPC   = 12'h341;
    localparam logic [11:0] CSR_MCAUSE = 12'h342;
    localparam logic [11:0] MCYCLE     = 12'hB00;
    localparam logic [11:0] MCYCLEH    = 12'hB80;

    localparam logic [31:0] CAUSE_ILLEGAL_INST = 32'd2;
    localparam logic [31:0] CAUSE_ECALL        = 32'd11;

    typedef enum logic [1:0] {
        CSR_NONE = 2'b00,
        CSR_RW   = 2'b01,
        CSR_RS   = 2'b10,
        CSR_RC   = 2'b11
    } csr_op_e;

    typedef enum logic {
        IDLE     = 1'b0,
        REDIRECT = 1'b1
    } trap_state_e;

    // New CSR value for a CSRRW/CSRRS/CSRRC given the old value and rs1/zimm.
    function automatic logic [31:0] csr_apply(csr_op_e op, logic [31:0] old_val,
                                              logic [31:0] wdata);
        case (op)
            CSR_RW:  return wdata;
            CSR_RS:  return old_val | wdata;
            CSR_RC:  return old_val & ~wdata;
            default: return old_val;
        endcase
    endfunction

endpackage

// File: rtl/rip_trap_csr_if.sv
// Execute-stage <-> CSR/trap unit bundle. master = execute/upstream side,
// slave = rip_trap_csr.
interface rip_trap_csr_if;
    logic        csr_valid;
    logic [1:0]  csr_op;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        trap_req;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic        mret;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;

    modport master (
        output csr_valid, csr_op, csr_addr, csr_wdata, trap_req, trap_cause, trap_pc, mret,
        input  csr_rdata, csr_illegal, redirect_valid, redirect_pc, busy
    );

    modport slave (
        input  csr_valid, csr_op, csr_addr, csr_wdata, trap_req, trap_cause, trap_pc, mret,
        output csr_rdata, csr_illegal, redirect_valid, redirect_pc, busy
    );
endinterface

// File: rtl/rip_trap_csr_counter.sv
// 64-bit free-running cycle counter with independent 32-bit half writes.
// A write to either half replaces the increment for the whole counter that
// cycle; the unwritten half holds. Only instantiated under RIP_CSR_MCYCLE_EN.
module rip_csr_counter (
    input  logic        clk,
    input  logic        rstn,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [63:0] cnt
);

    // Count every cycle unless software writes a half this cycle.
    always_ff @(posedge clk) begin
        if (!rstn)      cnt <= '0;
        else if (wr_lo) cnt <= {cnt[63:32], wdata};
        else if (wr_hi) cnt <= {wdata, cnt[31:0]};
        else            cnt <= cnt + 64'd1;
    end

endmodule

// File: rtl/rip_trap_csr.sv
// Machine-mode CSR file (mtvec/mepc/mcause) and trap/mret sequencer.
// Trap entry and mret each produce a one-cycle REDIRECT that drives
// redirect_valid/busy. Optional mcycle/mcycleh counter when the macro
// RIP_CSR_MCYCLE_EN is defined; otherwise 0xB00/0xB80 decode as illegal.
module rip_trap_csr
    import rip_trap_csr_pkg::*;
#(
    parameter logic [31:0] RESET_MTVEC = 32'h0
) (
    input  logic             clk,
    input  logic             rstn,
    rip_trap_csr_if.slave    bus
);

    trap_state_e state_q, state_d;
    logic [31:0] mtvec_q, mepc_q, mcause_q, redirect_pc_q;
    logic        legal;
    logic [31:0] old_val, new_val;
    logic        idle, take_trap, take_mret, csr_we;
    logic        we_mtvec, we_mepc, we_mcause;
    csr_op_e     op;

`ifdef RIP_CSR_MCYCLE_EN
    logic [63:0] mcycle;
    logic        we_mcycle, we_mcycleh;

    rip_csr_counter u_mcycle (
        .clk   (clk),
        .rstn  (rstn),
        .wr_lo (we_mcycle),
        .wr_hi (we_mcycleh),
        .wdata (new_val),
        .cnt   (mcycle)
    );
`endif

    assign op = csr_op_e'(bus.csr_op);

    // Address decode: legality and current value of the addressed CSR.
    always_comb begin
        legal   = 1'b1;
        old_val = '0;
        case (bus.csr_addr)
            CSR_MTVEC:  old_val = mtvec_q;
            CSR_MEPC:   old_val = mepc_q;
            CSR_MCAUSE: old_val = mcause_q;
`ifdef RIP_CSR_MCYCLE_EN
            MCYCLE:     old_val = mcycle[31:0];
            MCYCLEH:    old_val = mcycle[63:32];
`endif
            default:    legal   = 1'b0;
        endcase
    end

    assign bus.csr_illegal = bus.csr_valid && !legal;
    assign bus.csr_rdata   = (bus.csr_valid && legal) ? old_val : 32'h0;

    // Priority trap > mret > CSR write; nothing is accepted while redirecting.
    assign idle      = (state_q == IDLE);
    assign take_trap = idle && bus.trap_req;
    assign take_mret = idle && bus.mret && !bus.trap_req;
    assign csr_we    = idle && bus.csr_valid && (op != CSR_NONE) && legal
                       && !bus.trap_req && !bus.mret;
    assign new_val   = csr_apply(op, old_val, bus.csr_wdata);

    assign we_mtvec  = csr_we && (bus.csr_addr == CSR_MTVEC);
    assign we_mepc   = csr_we && (bus.csr_addr == CSR_MEPC);
    assign we_mcause = csr_we && (bus.csr_addr == CSR_MCAUSE);
`ifdef RIP_CSR_MCYCLE_EN
    assign we_mcycle  = csr_we && (bus.csr_addr == MCYCLE);
    assign we_mcycleh = csr_we && (bus.csr_addr == MCYCLEH);
`endif

    // Trap FSM state register.
    always_ff @(posedge clk) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Trap FSM next state: REDIRECT always lasts exactly one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (take_trap || take_mret) state_d = REDIRECT;
            REDIRECT: state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // CSR storage and redirect target capture.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            mtvec_q       <= RESET_MTVEC & ~32'h3;
            mepc_q        <= '0;
            mcause_q      <= '0;
            redirect_pc_q <= '0;
        end else begin
            if (take_trap) begin
                mepc_q        <= bus.trap_pc & ~32'h3;
                mcause_q      <= bus.trap_cause;
                redirect_pc_q <= mtvec_q;
            end else if (take_mret) begin
                redirect_pc_q <= mepc_q;
            end
            if (we_mtvec)  mtvec_q  <= new_val & ~32'h3;
            if (we_mepc)   mepc_q   <= new_val & ~32'h3;
            if (we_mcause) mcause_q <= new_val;
        end
    end

    assign bus.redirect_valid = (state_q == REDIRECT);
    assign bus.busy           = (state_q == REDIRECT);
    assign bus.redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_rip_trap_csr.sv
// Self-checking bench for rip_trap_csr: directed scenarios with literal
// expectations plus randomized traffic against a behavioural model.
// Honours RIP_CSR_MCYCLE_EN the same way the design does.
module tb_rip_trap_csr;
    import rip_trap_csr_pkg::*;

    localparam logic [31:0] RST_MTVEC = 32'h0;

    logic clk = 1'b0;
    logic rstn;
    int   n_cmp = 0;
    int   n_bad = 0;

    rip_trap_csr_if bus ();

    rip_trap_csr #(.RESET_MTVEC(RST_MTVEC)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    // Behavioural model state.
    logic [31:0] m_mtvec, m_mepc, m_mcause, m_rpc;
    logic        m_busy;
    logic [63:0] m_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_read(input logic [11:0] a, output logic lg, output logic [31:0] v);
        lg = 1'b1;
        v  = 32'h0;
        if (a == 12'h305)      v = m_mtvec;
        else if (a == 12'h341) v = m_mepc;
        else if (a == 12'h342) v = m_mcause;
`ifdef RIP_CSR_MCYCLE_EN
        else if (a == 12'hB00) v = m_cyc[31:0];
        else if (a == 12'hB80) v = m_cyc[63:32];
`endif
        else lg = 1'b0;
    endtask

    // Compare every output against the model (called once per cycle, mid-cycle).
    task automatic model_check();
        logic        lg;
        logic [31:0] v;
        chk("redirect_valid", {31'h0, bus.redirect_valid}, {31'h0, m_busy});
        chk("busy", {31'h0, bus.busy}, {31'h0, m_busy});
        chk("redirect_pc", bus.redirect_pc, m_rpc);
        model_read(bus.csr_addr, lg, v);
        chk("csr_illegal", {31'h0, bus.csr_illegal}, {31'h0, bus.csr_valid & ~lg});
        if (bus.csr_valid) chk("csr_rdata", bus.csr_rdata, lg ? v : 32'h0);
    endtask

    // Advance the model by one clock edge using the inputs being presented.
    task automatic model_update();
        logic        lg;
        logic [31:0] old, nv, w;
        logic [63:0] cyc_n;
        cyc_n = m_cyc + 64'd1;
        if (!rstn) begin
            m_mtvec = RST_MTVEC & ~32'h3; m_mepc = 0; m_mcause = 0;
            m_rpc = 0; m_busy = 0; cyc_n = 0;
        end else if (m_busy) begin
            m_busy = 1'b0;
        end else if (bus.trap_req) begin
            m_mepc = {bus.trap_pc[31:2], 2'b00};
            m_mcause = bus.trap_cause;
            m_rpc = m_mtvec;
            m_busy = 1'b1;
        end else if (bus.mret) begin
            m_rpc = m_mepc;
            m_busy = 1'b1;
        end else if (bus.csr_valid && bus.csr_op != 2'b00) begin
            model_read(bus.csr_addr, lg, old);
            w  = bus.csr_wdata;
            nv = (bus.csr_op == 2'b01) ? w : (bus.csr_op == 2'b10) ? (old | w) : (old & ~w);
            if (lg) begin
                if (bus.csr_addr == 12'h305)      m_mtvec = {nv[31:2], 2'b00};
                else if (bus.csr_addr == 12'h341) m_mepc = {nv[31:2], 2'b00};
                else if (bus.csr_addr == 12'h342) m_mcause = nv;
                else if (bus.csr_addr == 12'hB00) cyc_n = {m_cyc[63:32], nv};
                else                              cyc_n = {nv, m_cyc[31:0]};
            end
        end
        m_cyc = cyc_n;
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [11:0] a,
                         input logic [31:0] wd, input logic tr, input logic [31:0] cause,
                         input logic [31:0] pc, input logic mr);
        bus.csr_valid = v;  bus.csr_op = op;  bus.csr_addr = a;  bus.csr_wdata = wd;
        bus.trap_req = tr;  bus.trap_cause = cause;  bus.trap_pc = pc;  bus.mret = mr;
    endtask

    task automatic idle_in();
        drive(0, 2'b00, 12'h000, 0, 0, 0, 0, 0);
    endtask

    task automatic settle();
        @(negedge clk);
        model_check();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        m_mtvec = 0; m_mepc = 0; m_mcause = 0; m_rpc = 0; m_busy = 0; m_cyc = 0;
        rstn = 1'b0;
        idle_in();
        tick(); tick();
        rstn = 1'b1;

        // Reset state.
        settle();
        chk("rst_redirect_valid", {31'h0, bus.redirect_valid}, 32'h0);
        chk("rst_busy", {31'h0, bus.busy}, 32'h0);
        chk("rst_redirect_pc", bus.redirect_pc, 32'h0);
        tick();

        // CSRRW mtvec: old value returned, low bits dropped on write.
        drive(1, 2'b01, CSR_MTVEC, 32'h0000_1003, 0, 0, 0, 0);
        settle(); chk("t1_rdata_old", bus.csr_rdata, 32'h0); tick();
        drive(1, 2'b00, CSR_MTVEC, 0, 0, 0, 0, 0);
        settle(); chk("t1_rdata_new", bus.csr_rdata, 32'h0000_1000); tick();

        // Trap entry.
        drive(0, 2'b00, 0, 0, 1, CAUSE_ECALL, 32'h0000_0204, 0);
        settle(); tick();
        idle_in();
        settle();
        chk("t2_redirect_valid", {31'h0, bus.redirect_valid}, 32'h1);
        chk("t2_redirect_pc", bus.redirect_pc, 32'h0000_1000);
        chk("t2_busy", {31'h0, bus.busy}, 32'h1);
        tick();
        drive(1, 2'b00, CSR_MEPC, 0, 0, 0, 0, 0);
        settle();
        chk("t2_redirect_drop", {31'h0, bus.redirect_valid}, 32'h0);
        chk("t2_mepc", bus.csr_rdata, 32'h0000_0204);
        tick();
        drive(1, 2'b00, CSR_MCAUSE, 0, 0, 0, 0, 0);
        settle(); chk("t2_mcause", bus.csr_rdata, 32'd11); tick();

        // mret to 0x208.
        drive(1, 2'b01, CSR_MEPC, 32'h0000_0208, 0, 0, 0, 0);
        settle(); tick();
        drive(0, 2'b00, 0, 0, 0, 0, 0, 1);
        settle(); tick();
        idle_in();
        settle();
        chk("t3_redirect_valid", {31'h0, bus.redirect_valid}, 32'h1);
        chk("t3_redirect_pc", bus.redirect_pc, 32'h0000_0208);
        tick();
        drive(1, 2'b00, CSR_MCAUSE, 0, 0, 0, 0, 0);
        settle(); chk("t3_mcause_kept", bus.csr_rdata, 32'd11); tick();

        // Set / clear / illegal address.
        drive(1, 2'b01, CSR_MCAUSE, 32'h2, 0, 0, 0, 0); settle(); tick();
        drive(1, 2'b10, CSR_MCAUSE, 32'h4, 0, 0, 0, 0);
        settle(); chk("t4_rs_old", bus.csr_rdata, 32'h2); tick();
        drive(1, 2'b11, CSR_MCAUSE, 32'h2, 0, 0, 0, 0);
        settle(); chk("t4_rc_old", bus.csr_rdata, 32'h6); tick();
        drive(1, 2'b01, 12'h7C0, 32'hFFFF_FFFF, 0, 0, 0, 0);
        settle();
        chk("t4_illegal", {31'h0, bus.csr_illegal}, 32'h1);
        chk("t4_illegal_rdata", bus.csr_rdata, 32'h0);
        tick();
        drive(1, 2'b00, CSR_MCAUSE, 0, 0, 0, 0, 0);
        settle();
        chk("t4_rc_new", bus.csr_rdata, 32'h4);
        chk("t4_legal", {31'h0, bus.csr_illegal}, 32'h0);
        tick();

        // trap + mret + CSR write together: trap wins, write dropped.
        drive(1, 2'b01, CSR_MTVEC, 32'h0000_5000, 1, CAUSE_ILLEGAL_INST, 32'h0000_0302, 1);
        settle(); tick();
        idle_in();
        settle(); chk("t5_redirect_pc", bus.redirect_pc, 32'h0000_1000); tick();
        drive(1, 2'b00, CSR_MTVEC, 0, 0, 0, 0, 0);
        settle(); chk("t5_mtvec_kept", bus.csr_rdata, 32'h0000_1000); tick();
        drive(1, 2'b00, CSR_MEPC, 0, 0, 0, 0, 0);
        settle(); chk("t5_mepc", bus.csr_rdata, 32'h0000_0300); tick();
        // Reset while in REDIRECT.
        drive(0, 2'b00, 0, 0, 1, CAUSE_ECALL, 32'h40, 0);
        settle(); tick();
        idle_in();
        rstn = 1'b0;
        settle(); chk("t5_in_redirect", {31'h0, bus.redirect_valid}, 32'h1); tick();
        rstn = 1'b1;
        settle();
        chk("t5_rst_abort", {31'h0, bus.redirect_valid}, 32'h0);
        chk("t5_rst_busy", {31'h0, bus.busy}, 32'h0);
        tick();

`ifdef RIP_CSR_MCYCLE_EN
        drive(1, 2'b01, MCYCLEH, 32'h5, 0, 0, 0, 0); settle(); tick();
        drive(1, 2'b01, MCYCLE, 32'hFFFF_FFFF, 0, 0, 0, 0); settle(); tick();
        drive(1, 2'b00, MCYCLE, 0, 0, 0, 0, 0);
        settle(); chk("t6_mcycle_lo", bus.csr_rdata, 32'hFFFF_FFFF); tick();
        drive(1, 2'b00, MCYCLEH, 0, 0, 0, 0, 0);
        settle(); chk("t6_mcycle_hi_inc", bus.csr_rdata, 32'h6); tick();
`else
        drive(1, 2'b00, 12'hB00, 0, 0, 0, 0, 0);
        settle(); chk("t6_mcycle_illegal", {31'h0, bus.csr_illegal}, 32'h1); tick();
        drive(1, 2'b10, 12'hB80, 32'h1, 0, 0, 0, 0);
        settle(); chk("t6_mcycleh_illegal", {31'h0, bus.csr_illegal}, 32'h1); tick();
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [11:0] a;
            logic [31:0] wd;
            case ($urandom_range(0, 5))
                0: a = CSR_MTVEC;
                1: a = CSR_MEPC;
                2: a = CSR_MCAUSE;
                3: a = MCYCLE;
                4: a = MCYCLEH;
                default: a = 12'($urandom);
            endcase
            wd = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            drive(1'($urandom_range(0, 1)), 2'($urandom), a, wd,
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 1) == 0) ? CAUSE_ECALL : $urandom,
                  $urandom, ($urandom_range(0, 7) == 0));
            rstn = ($urandom_range(0, 99) != 0);
            settle();
            tick();
        end
        rstn = 1'b1;
        idle_in();
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
